// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO over its read interface and serialises each byte as an 8N1 UART frame.
// Frame timing is measured from the edge that loads the byte, and consecutive frames are
// spaced 10 * ClksPerBit + 2 cycles apart.
module fifo_uart_tx #(
  parameter int unsigned ClksPerBit = 1085,
  parameter int unsigned DataWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_en_i,
  input  logic                 fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_dout_i,
  output logic                 fifo_rd_en_o,
  output logic                 serial_out_o,
  output logic                 busy_o
);

  localparam int unsigned BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e               state_q;
  logic [BaudW-1:0]     baud_q;
  logic [BitW-1:0]      bit_q;
  logic [DataWidth-1:0] shift_q;
  logic                 serial_q;
  logic                 bit_end;

  assign bit_end = (baud_q == BaudLast);

  // Gated by reset as well, so the FIFO is never popped while this block is held in reset.
  assign fifo_rd_en_o = rst_ni & (state_q == StIdle) & tx_en_i & ~fifo_empty_i;
  assign serial_out_o = serial_q;
  assign busy_o       = (state_q != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          serial_q <= 1'b1;
          if (fifo_rd_en_o) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          shift_q  <= fifo_dout_i;
          serial_q <= 1'b0;
          baud_q   <= '0;
          bit_q    <= '0;
          state_q  <= StStart;
        end
        StStart: begin
          if (bit_end) begin
            baud_q   <= '0;
            serial_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bit_q    <= '0;
            state_q  <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == BitLast) begin
              serial_q <= 1'b1;
              state_q  <= StStop;
            end else begin
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
              bit_q    <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural byte FIFO feeds the DUT, and a UART line monitor
// checks every frame cycle by cycle against a scoreboard of expected bytes.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         starts_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int cyc     = 0;
  int rd_base;

  bit         mon_act = 1'b0;
  int         mon_k   = 0;
  logic [9:0] mon_frame;
  logic [7:0] mon_rx;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .ClksPerBit(CPB),
    .DataWidth (8)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tx_en_i     (tx_en),
    .fifo_empty_i(fifo_empty),
    .fifo_dout_i (fifo_dout),
    .fifo_rd_en_o(fifo_rd_en),
    .serial_out_o(serial_out),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered dout, writes and pops on the rising edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      check_eq("rd_when_empty", 32'(fifo_q.size() == 0), 0);
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  // UART monitor: sync on the falling start edge, then check each cycle of the frame.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act && serial_out == 1'b0) begin
        mon_act = 1'b1;
        mon_k   = 0;
        mon_rx  = 8'h00;
        starts_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'(exp_q.size()), 1);
          mon_frame = 10'h3fe;
        end else begin
          mon_frame = {1'b1, exp_q[0], 1'b0};
        end
      end
      if (mon_act) begin
        check_eq("line_bit", serial_out, mon_frame[mon_k/CPB]);
        if ((mon_k % CPB) == CPB / 2 && mon_k / CPB >= 1 && mon_k / CPB <= 8) begin
          mon_rx[mon_k/CPB-1] = serial_out;
        end
        mon_k++;
        if (mon_k == 10 * CPB) begin
          mon_act = 1'b0;
          if (exp_q.size() > 0) check_eq("rx_byte", mon_rx, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_tx);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_tx) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (n < max && !(exp_q.size() == 0 && !mon_act && !busy)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq(tag, 32'(n < max), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    tx_en = 1'b0;
    #2;
    // 1: reset takes effect at once and holds the outputs quiet
    rst_n = 1'b0;
    #1;
    check_eq("rst_serial", serial_out, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rst_hold_serial", serial_out, 1);
      check_eq("rst_hold_busy", busy, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 2: single byte
    rd_base = rd_cnt;
    tx_en   = 1'b1;
    push(8'hA5, 1'b1);
    wait_done("t2_done", 200);
    check_eq("t2_rd_count", rd_cnt - rd_base, 1);
    check_eq("t2_idle_serial", serial_out, 1);
    check_eq("t2_idle_busy", busy, 0);

    // 3: back-to-back burst
    starts_q.delete();
    rd_base = rd_cnt;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    wait_done("t3_done", 400);
    check_eq("t3_rd_count", rd_cnt - rd_base, 3);
    check_eq("t3_frames", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      check_eq("t3_gap1", starts_q[1] - starts_q[0], 10 * CPB + 2);
      check_eq("t3_gap2", starts_q[2] - starts_q[1], 10 * CPB + 2);
    end
    check_eq("t3_empty", fifo_empty, 1);

    // 4: empty FIFO never popped; tx_en low holds queued bytes
    rd_base = rd_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("t4_rd_en_empty", fifo_rd_en, 0);
      check_eq("t4_serial_idle", serial_out, 1);
    end
    tx_en = 1'b0;
    push(8'h5A, 1'b1);
    push(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("t4_hold_rd", rd_cnt - rd_base, 0);
    check_eq("t4_hold_busy", busy, 0);
    check_eq("t4_hold_nonempty", fifo_empty, 0);
    tx_en = 1'b1;
    wait_done("t4_done", 300);
    check_eq("t4_rd_count", rd_cnt - rd_base, 2);

    // 5: tx_en drops during data bit 3; frame finishes, next byte stays queued
    rd_base = rd_cnt;
    push(8'h81, 1'b1);
    push(8'h42, 1'b0);
    repeat (18) @(negedge clk);
    tx_en = 1'b0;
    check_eq("t5_busy_mid", busy, 1);
    wait_done("t5_done", 200);
    repeat (50) @(negedge clk);
    check_eq("t5_rd_count", rd_cnt - rd_base, 1);
    check_eq("t5_nonempty", fifo_empty, 0);
    check_eq("t5_busy", busy, 0);

    // 6: reset during DATA drops the byte in flight; next byte goes out cleanly
    rd_base = rd_cnt;
    exp_q.push_back(8'h42);
    tx_en = 1'b1;
    push(8'h99, 1'b1);
    repeat (12) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_serial", serial_out, 1);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_rd_en", fifo_rd_en, 0);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    check_eq("t6_rst_hold_serial", serial_out, 1);
    rst_n = 1'b1;
    wait_done("t6_done", 200);
    check_eq("t6_rd_count", rd_cnt - rd_base, 2);
    check_eq("t6_empty", fifo_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
